// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported word memory between the fetch port and the data port.
// Latency: mem_valid one cycle after grant; done one cycle after mem_ready (or after a timeout abort).
// Backpressure: requesters hold req until done; the memory stalls via mem_ready, with the wait bounded by TIMEOUT_CYCLES.
module mem_port_arbiter #(
    parameter int DATA_PRIORITY  = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err,
    output logic        err_sticky
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA, S_RESP} state_t;

    localparam logic [15:0] TMO    = 16'(TIMEOUT_CYCLES);
    localparam bit          TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam bit          DPRI   = (DATA_PRIORITY != 0);

    state_t      state_q, state_d;
    logic        last_dm_q, last_dm_d;   // 1 = most recent grant went to the data port
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        valid_q, valid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        if_done_q, if_done_d;
    logic        dm_done_q, dm_done_d;
    logic        err_q, err_d;
    logic        sticky_q, sticky_d;
    logic [15:0] wait_q, wait_d;
    logic        grant_dm;
    logic        abort;

    // The byte offset is dropped: the memory is word addressed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

    // State and datapath registers; reset abandons any in-flight transaction without a done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            last_dm_q  <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            valid_q    <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            err_q      <= 1'b0;
            sticky_q   <= 1'b0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_dm_q  <= last_dm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            valid_q    <= valid_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            err_q      <= err_d;
            sticky_q   <= sticky_d;
            wait_q     <= wait_d;
        end
    end

    // Arbitration, transaction sequencing and next values of every registered output.
    always_comb begin
        state_d    = state_q;
        last_dm_d  = last_dm_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        valid_d    = valid_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        err_d      = 1'b0;
        sticky_d   = sticky_q;
        wait_d     = wait_q;
        grant_dm   = 1'b0;
        abort      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Data wins a tie under fixed priority; otherwise the port not served last.
                grant_dm = dm_req && (!if_req || DPRI || !last_dm_q);
                if (grant_dm) begin
                    state_d   = S_DATA;
                    last_dm_d = 1'b1;
                    we_d      = dm_we;
                    addr_d    = {dm_addr[31:2], 2'b00};
                    wdata_d   = dm_wdata;
                    valid_d   = 1'b1;
                    wait_d    = '0;
                end else if (if_req) begin
                    state_d   = S_FETCH;
                    last_dm_d = 1'b0;
                    we_d      = 1'b0;
                    addr_d    = {if_addr[31:2], 2'b00};
                    wdata_d   = '0;
                    valid_d   = 1'b1;
                    wait_d    = '0;
                end
            end

            S_FETCH, S_DATA: begin
                // A ready memory always completes; the abort only fires on a still-stalled cycle.
                abort = TMO_EN && !mem_ready && (wait_q == TMO);
                if (mem_ready || abort) begin
                    state_d = S_RESP;
                    valid_d = 1'b0;
                    err_d   = abort;
                    if (abort) begin
                        sticky_d = 1'b1;
                    end
                    if (state_q == S_FETCH) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = abort ? 32'h0 : mem_rdata;
                    end else begin
                        dm_done_d = 1'b1;
                        if (!we_q) begin
                            dm_rdata_d = abort ? 32'h0 : mem_rdata;
                        end
                    end
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign if_rdata   = if_rdata_q;
    assign if_done    = if_done_q;
    assign dm_rdata   = dm_rdata_q;
    assign dm_done    = dm_done_q;
    assign mem_valid  = valid_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance a uses fixed data priority with a short timeout,
// instance b uses round-robin with the default timeout and is driven by a random
// transaction-level model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // Instance a: DATA_PRIORITY=1, TIMEOUT_CYCLES=4
    logic        a_if_req, a_if_done, a_dm_req, a_dm_we, a_dm_done;
    logic [31:0] a_if_addr, a_if_rdata, a_dm_addr, a_dm_wdata, a_dm_rdata;
    logic        a_mem_valid, a_mem_we, a_mem_ready, a_busy, a_err, a_err_sticky;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    // Instance b: DATA_PRIORITY=0, TIMEOUT_CYCLES=255
    logic        b_if_req, b_if_done, b_dm_req, b_dm_we, b_dm_done;
    logic [31:0] b_if_addr, b_if_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata;
    logic        b_mem_valid, b_mem_we, b_mem_ready, b_busy, b_err, b_err_sticky;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(4)) u_a (
        .clk(clk), .reset(reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_done(a_if_done),
        .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
        .dm_rdata(a_dm_rdata), .dm_done(a_dm_done),
        .mem_valid(a_mem_valid), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_ready(a_mem_ready), .mem_rdata(a_mem_rdata),
        .busy(a_busy), .err(a_err), .err_sticky(a_err_sticky)
    );

    mem_port_arbiter #(.DATA_PRIORITY(0), .TIMEOUT_CYCLES(255)) u_b (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_done(b_if_done),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_rdata(b_dm_rdata), .dm_done(b_dm_done),
        .mem_valid(b_mem_valid), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_ready(b_mem_ready), .mem_rdata(b_mem_rdata),
        .busy(b_busy), .err(b_err), .err_sticky(b_err_sticky)
    );

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_a(input string t);
        chk({t, " mem_valid"},  a_mem_valid,  32'h0);
        chk({t, " mem_we"},     a_mem_we,     32'h0);
        chk({t, " mem_addr"},   a_mem_addr,   32'h0);
        chk({t, " mem_wdata"},  a_mem_wdata,  32'h0);
        chk({t, " if_done"},    a_if_done,    32'h0);
        chk({t, " dm_done"},    a_dm_done,    32'h0);
        chk({t, " if_rdata"},   a_if_rdata,   32'h0);
        chk({t, " dm_rdata"},   a_dm_rdata,   32'h0);
        chk({t, " err"},        a_err,        32'h0);
        chk({t, " err_sticky"}, a_err_sticky, 32'h0);
        chk({t, " busy"},       a_busy,       32'h0);
    endtask

    typedef struct {
        logic        dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          waits;      // stall cycles before mem_ready; 99 = never ready
        logic [31:0] exp_addr;
        logic [31:0] exp_rd;
        int          exp_lat;    // cycles from first mem_valid cycle to done
        logic        exp_err;
        logic        exp_sticky;
    } vec_t;

    vec_t vecs[7];

    // Random-phase model state for instance b
    logic        pend_if, pend_dm;
    logic        last_dm;
    logic [31:0] ram [16];
    logic [31:0] exp_if_rd, exp_dm_rd;

    task automatic refresh_b;
        if (!pend_if && ($urandom_range(0, 1) == 1)) begin
            pend_if   = 1'b1;
            b_if_addr = $urandom;
        end
        if (!pend_dm && ($urandom_range(0, 1) == 1)) begin
            pend_dm    = 1'b1;
            b_dm_addr  = $urandom;
            b_dm_we    = 1'($urandom_range(0, 1));
            b_dm_wdata = $urandom;
        end
        if (!pend_if && !pend_dm) begin
            pend_if   = 1'b1;
            b_if_addr = $urandom;
        end
        b_if_req = pend_if;
        b_dm_req = pend_dm;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        v;
        int          lat;
        logic        done;
        logic        stable;
        int          k;
        logic        both;
        logic        order [4];
        logic        g_dm;
        logic [31:0] ea;
        logic [3:0]  idx;
        int          w;

        reset = 1'b1;
        a_if_req = 0; a_if_addr = 0; a_dm_req = 0; a_dm_we = 0; a_dm_addr = 0; a_dm_wdata = 0;
        a_mem_ready = 0; a_mem_rdata = 0;
        b_if_req = 0; b_if_addr = 0; b_dm_req = 0; b_dm_we = 0; b_dm_addr = 0; b_dm_wdata = 0;
        b_mem_ready = 0; b_mem_rdata = 0;

        //                dm    we    addr       wdata         mrd           waits exp_addr   exp_rd        lat err   sticky
        vecs[0] = '{1'b1, 1'b0, 32'h103,   32'h0,        32'hDEADBEEF, 0,  32'h100,   32'hDEADBEEF, 1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'h2000,  32'h0,        32'h13579BDF, 3,  32'h2000,  32'h13579BDF, 4, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h40,    32'h55,       32'hFFFF0000, 1,  32'h40,    32'hDEADBEEF, 2, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h7,     32'h0,        32'hA5A5A5A5, 2,  32'h4,     32'hA5A5A5A5, 3, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h1FE,   32'h0,        32'h11111111, 99, 32'h1FC,   32'h0,        5, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 32'h300,   32'h0,        32'h12345678, 0,  32'h300,   32'h12345678, 1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 32'h500,   32'h0,        32'h22222222, 99, 32'h500,   32'h0,        5, 1'b1, 1'b1};

        // Reset values
        tick;
        tick;
        chk_idle_a("reset");
        chk("reset b mem_valid", b_mem_valid, 32'h0);
        chk("reset b busy", b_busy, 32'h0);
        reset = 1'b0;
        tick;

        // Single transactions on instance a from the vector table
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            a_if_req = !v.dm; a_dm_req = v.dm;
            a_if_addr = v.addr; a_dm_addr = v.addr; a_dm_we = v.we; a_dm_wdata = v.wdata;
            a_mem_ready = 1'b0;
            tick;
            chk($sformatf("v%0d mem_valid", i), a_mem_valid, 32'h1);
            chk($sformatf("v%0d mem_addr", i), a_mem_addr, v.exp_addr);
            chk($sformatf("v%0d mem_we", i), a_mem_we, {31'h0, v.dm & v.we});
            chk($sformatf("v%0d mem_wdata", i), a_mem_wdata, v.dm ? v.wdata : 32'h0);
            // Requester inputs change after grant; the transaction must not notice.
            a_if_addr = ~v.addr; a_dm_addr = ~v.addr; a_dm_wdata = ~v.wdata; a_dm_we = ~v.we;
            lat = 0; done = 1'b0; stable = 1'b1;
            while (!done && lat < 20) begin
                a_mem_ready = (lat == v.waits);
                a_mem_rdata = v.mrd;
                tick;
                lat++;
                if (a_if_done || a_dm_done) done = 1'b1;
                else if (a_mem_addr !== v.exp_addr || a_mem_valid !== 1'b1) stable = 1'b0;
            end
            chk($sformatf("v%0d latency", i), lat, v.exp_lat);
            chk($sformatf("v%0d addr_stable", i), stable, 32'h1);
            chk($sformatf("v%0d dm_done", i), a_dm_done, {31'h0, v.dm});
            chk($sformatf("v%0d if_done", i), a_if_done, {31'h0, !v.dm});
            chk($sformatf("v%0d rdata", i), v.dm ? a_dm_rdata : a_if_rdata, v.exp_rd);
            chk($sformatf("v%0d err", i), a_err, {31'h0, v.exp_err});
            chk($sformatf("v%0d err_sticky", i), a_err_sticky, {31'h0, v.exp_sticky});
            a_if_req = 1'b0; a_dm_req = 1'b0; a_mem_ready = 1'b0;
            tick;
            chk($sformatf("v%0d busy_after", i), a_busy, 32'h0);
            chk($sformatf("v%0d done_cleared", i), {a_if_done, a_dm_done}, 32'h0);
            chk($sformatf("v%0d err_cleared", i), a_err, 32'h0);
        end

        // Simultaneous store and fetch under data priority, zero-wait memory
        a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 32'h40; a_dm_wdata = 32'h55;
        a_if_req = 1'b1; a_if_addr = 32'h80;
        a_mem_ready = 1'b1; a_mem_rdata = 32'h77777777;
        tick;
        chk("sim store mem_we", a_mem_we, 32'h1);
        chk("sim store mem_wdata", a_mem_wdata, 32'h55);
        chk("sim store mem_addr", a_mem_addr, 32'h40);
        tick;
        chk("sim dm_done", a_dm_done, 32'h1);
        chk("sim if_done early", a_if_done, 32'h0);
        a_dm_req = 1'b0;
        tick;
        chk("sim gap mem_valid", a_mem_valid, 32'h0);
        tick;
        chk("sim fetch mem_valid", a_mem_valid, 32'h1);
        chk("sim fetch mem_we", a_mem_we, 32'h0);
        chk("sim fetch mem_addr", a_mem_addr, 32'h80);
        chk("sim fetch mem_wdata", a_mem_wdata, 32'h0);
        tick;
        chk("sim if_done", a_if_done, 32'h1);
        chk("sim if_rdata", a_if_rdata, 32'h77777777);
        a_if_req = 1'b0; a_mem_ready = 1'b0;
        tick;

        // Fetch request dropped right after grant still completes
        a_if_req = 1'b1; a_if_addr = 32'h900;
        tick;
        chk("drop mem_valid", a_mem_valid, 32'h1);
        a_if_req = 1'b0;
        tick;
        tick;
        a_mem_ready = 1'b1; a_mem_rdata = 32'h2468ACE0;
        tick;
        chk("drop if_done", a_if_done, 32'h1);
        chk("drop if_rdata", a_if_rdata, 32'h2468ACE0);
        a_mem_ready = 1'b0;
        tick;
        chk("drop busy", a_busy, 32'h0);

        // Reset while a load waits on the memory
        a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h44;
        tick;
        tick;
        chk("rstmid busy before", a_busy, 32'h1);
        reset = 1'b1;
        tick;
        chk_idle_a("rstmid");
        reset = 1'b0; a_dm_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("rstmid no dm_done", a_dm_done, 32'h0);
        end

        // Round-robin instance with both requests held over four transactions
        b_if_req = 1'b1; b_if_addr = 32'h20;
        b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 32'h10;
        b_mem_ready = 1'b1; b_mem_rdata = 32'h0BADCAFE;
        k = 0; both = 1'b0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            tick;
            if (b_if_done && b_dm_done) both = 1'b1;
            if (b_if_done || b_dm_done) begin
                order[k] = b_dm_done;
                k++;
                if (k == 4) begin
                    b_if_req = 1'b0; b_dm_req = 1'b0;
                end
            end
        end
        b_mem_ready = 1'b0;
        chk("rr completions", k, 32'd4);
        chk("rr both_done", both, 32'h0);
        if (k == 4) begin
            chk("rr grant0 fetch", order[0], 32'h0);
            chk("rr grant1 data",  order[1], 32'h1);
            chk("rr grant2 fetch", order[2], 32'h0);
            chk("rr grant3 data",  order[3], 32'h1);
        end
        tick;

        // Random traffic on instance b against a transaction-level model
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) ram[i] = $urandom;
        exp_if_rd = 32'h0; exp_dm_rd = 32'h0; last_dm = 1'b1;
        pend_if = 1'b0; pend_dm = 1'b0;
        refresh_b();
        for (int t = 0; t < 200; t++) begin
            k = 0;
            do begin
                tick;
                k++;
            end while (!b_mem_valid && k < 6);
            chk("rnd mem_valid", b_mem_valid, 32'h1);
            // Tie goes to the port that was not served last.
            g_dm = pend_dm && (!pend_if || !last_dm);
            last_dm = g_dm;
            ea = g_dm ? b_dm_addr : b_if_addr;
            ea = {ea[31:2], 2'b00};
            idx = ea[5:2];
            chk("rnd mem_addr", b_mem_addr, ea);
            chk("rnd mem_we", b_mem_we, {31'h0, g_dm & b_dm_we});
            chk("rnd mem_wdata", b_mem_wdata, g_dm ? b_dm_wdata : 32'h0);
            w = $urandom_range(0, 3);
            for (int s = 0; s < w; s++) tick;
            b_mem_ready = 1'b1;
            b_mem_rdata = ram[idx];
            tick;
            b_mem_ready = 1'b0;
            chk("rnd dm_done", b_dm_done, {31'h0, g_dm});
            chk("rnd if_done", b_if_done, {31'h0, !g_dm});
            chk("rnd err", b_err, 32'h0);
            if (g_dm) begin
                if (b_dm_we) ram[idx] = b_dm_wdata;
                else exp_dm_rd = ram[idx];
                chk("rnd dm_rdata", b_dm_rdata, exp_dm_rd);
                pend_dm = 1'b0;
            end else begin
                exp_if_rd = ram[idx];
                chk("rnd if_rdata", b_if_rdata, exp_if_rd);
                pend_if = 1'b0;
            end
            refresh_b();
        end
        b_if_req = 1'b0; b_dm_req = 1'b0;
        tick;
        tick;
        chk("rnd err_sticky", b_err_sticky, 32'h0);
        chk("rnd idle busy", b_busy, 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
